// File: rtl/shift_seq_pkg.sv
// Shared types for the EBOX shift sequencer.
// Step encodings, select enums and count helpers.
package shift_seq_pkg;

  localparam int MAX_STEPS = 4;

  localparam logic [1:0] SH_SHIFT = 2'b00;
  localparam logic [1:0] SH_AR    = 2'b01;

  typedef enum logic [1:0] {
    OP_LSH  = 2'b00,
    OP_ROT  = 2'b01,
    OP_LSHC = 2'b10,
    OP_ROTC = 2'b11
  } shop_t;

  typedef enum logic [2:0] {
    AR_HOLD = 3'd0,
    AR_SH   = 3'd1,
    AR_ARX  = 3'd2,
    AR_BR   = 3'd3,
    AR_ZERO = 3'd4
  } ar_sel_t;

  typedef enum logic [2:0] {
    ARX_HOLD = 3'd0,
    ARX_SH   = 3'd1,
    ARX_AR   = 3'd2,
    ARX_BR   = 3'd3,
    ARX_ZERO = 3'd4
  } arx_sel_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] sc;
    ar_sel_t    ar_sel;
    arx_sel_t   arx_sel;
    logic       br_load;
  } step_t;

  localparam step_t STEP_IDLE = '{
    sc:      6'd0,
    ar_sel:  AR_HOLD,
    arx_sel: ARX_HOLD,
    br_load: 1'b0
  };

  function automatic step_t mk_step(
    input logic [5:0] sc,
    input ar_sel_t    a,
    input arx_sel_t   x,
    input logic       br
  );
    step_t s;
    s.sc      = sc;
    s.ar_sel  = a;
    s.arx_sel = x;
    s.br_load = br;
    return s;
  endfunction

  // The funnel output is needed whenever any load (incl. BR) takes SH.
  function automatic logic [1:0] func_of(input step_t s);
    if (s.ar_sel == AR_SH || s.arx_sel == ARX_SH || s.br_load)
      return SH_SHIFT;
    return SH_AR;
  endfunction

  // n is at most 256, so three subtract stages reach n mod 36.
  function automatic logic [8:0] mod36(input logic [8:0] v);
    logic [8:0] t;
    t = v;
    if (t >= 9'd144) t = t - 9'd144;
    if (t >= 9'd72)  t = t - 9'd72;
    if (t >= 9'd36)  t = t - 9'd36;
    return t;
  endfunction

  function automatic logic [8:0] mod72(input logic [8:0] v);
    logic [8:0] t;
    t = v;
    if (t >= 9'd144) t = t - 9'd144;
    if (t >= 9'd72)  t = t - 9'd72;
    return t;
  endfunction

endpackage

// File: rtl/shift_count_reduce.sv
// Count reduction for the shift sequencer.
// Maps op and count to a step list of up to four cycles.
module shift_count_reduce
  import shift_seq_pkg::*;
(
  input  shop_t                       op,
  input  logic [8:0]                  count,
  output logic [2:0]                  m,
  output step_t [MAX_STEPS-1:0]       steps
);

  logic       neg;
  logic [8:0] n;
  logic [8:0] r36;
  logic [8:0] r72;
  logic [5:0] rot_r;
  logic [6:0] rc;
  logic       rc_hi;
  logic [6:0] rc_lo;
  logic [5:0] k;
  logic [5:0] n6;

  assign neg = count[8];
  assign n   = neg ? (~count + 9'd1) : count;
  assign n6  = n[5:0];
  assign r36 = mod36(n);
  assign r72 = mod72(n);
  assign k   = 6'(n - 9'd36);

  assign rot_r = (neg && r36 != 9'd0) ? 6'(9'd36 - r36)
                                      : r36[5:0];
  assign rc    = (neg && r72 != 9'd0) ? 7'(9'd72 - r72)
                                      : r72[6:0];
  assign rc_hi = rc >= 7'd36;
  assign rc_lo = rc_hi ? rc - 7'd36 : rc;

  // Build the step list by appending entries in issue order.
  always_comb begin
    m     = 3'd0;
    steps = {MAX_STEPS{STEP_IDLE}};
    unique case (op)
      OP_LSH: begin
        if (n >= 9'd36) begin
          steps[0] = mk_step(6'd0, AR_ZERO, ARX_HOLD, 1'b0);
          m = 3'd1;
        end else if (n != 9'd0) begin
          if (!neg) begin
            steps[0] = mk_step(6'd0, AR_HOLD, ARX_ZERO, 1'b0);
            steps[1] = mk_step(n6, AR_SH, ARX_HOLD, 1'b0);
          end else begin
            steps[0] = mk_step(6'd0, AR_ZERO, ARX_AR, 1'b0);
            steps[1] = mk_step(6'd36 - n6, AR_SH, ARX_HOLD, 1'b0);
          end
          m = 3'd2;
        end
      end
      OP_ROT: begin
        if (rot_r != 6'd0) begin
          steps[0] = mk_step(6'd0, AR_HOLD, ARX_AR, 1'b0);
          steps[1] = mk_step(rot_r, AR_SH, ARX_HOLD, 1'b0);
          m = 3'd2;
        end
      end
      OP_ROTC: begin
        if (rc_hi) begin
          steps[m[1:0]] = mk_step(6'd0, AR_ARX, ARX_AR, 1'b0);
          m = m + 3'd1;
        end
        if (rc_lo != 7'd0) begin
          steps[m[1:0]] = mk_step(rc_lo[5:0], AR_HOLD, ARX_HOLD, 1'b1);
          m = m + 3'd1;
          steps[m[1:0]] = mk_step(6'd0, AR_ARX, ARX_AR, 1'b0);
          m = m + 3'd1;
          steps[m[1:0]] = mk_step(rc_lo[5:0], AR_BR, ARX_SH, 1'b0);
          m = m + 3'd1;
        end
      end
      OP_LSHC: begin
        if (n >= 9'd72) begin
          steps[0] = mk_step(6'd0, AR_ZERO, ARX_ZERO, 1'b0);
          m = 3'd1;
        end else if (n >= 9'd36) begin
          if (!neg) begin
            steps[0] = mk_step(6'd0, AR_ARX, ARX_ZERO, 1'b0);
            steps[1] = mk_step(k, AR_SH, ARX_HOLD, 1'b0);
          end else begin
            steps[0] = mk_step(6'd0, AR_ZERO, ARX_AR, 1'b0);
            steps[1] = mk_step(6'd36 - k, AR_HOLD, ARX_SH, 1'b0);
          end
          m = (k != 6'd0) ? 3'd2 : 3'd1;
        end else if (n != 9'd0) begin
          if (!neg) begin
            steps[0] = mk_step(n6, AR_HOLD, ARX_HOLD, 1'b1);
            steps[1] = mk_step(6'd0, AR_ARX, ARX_ZERO, 1'b0);
            steps[2] = mk_step(n6, AR_BR, ARX_SH, 1'b0);
          end else begin
            steps[0] = mk_step(6'd36 - n6, AR_HOLD, ARX_HOLD, 1'b1);
            steps[1] = mk_step(6'd0, AR_ZERO, ARX_AR, 1'b0);
            steps[2] = mk_step(6'd36 - n6, AR_SH, ARX_BR, 1'b0);
          end
          m = 3'd3;
        end
      end
      default: m = 3'd0;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// EBOX funnel shift sequencer top.
// Buffers the reduced step list at start and plays it out.
module shift_seq
  import shift_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [8:0] count,
  output logic       busy,
  output logic       done,
  output logic [1:0] sh_func,
  output logic [5:0] sc,
  output logic [2:0] ar_sel,
  output logic [2:0] arx_sel,
  output logic       br_load
);

  state_t                 state;
  state_t                 state_n;
  logic [1:0]             idx;
  logic [1:0]             idx_n;
  logic [2:0]             m_q;
  step_t [MAX_STEPS-1:0]  sbuf;
  logic [2:0]             red_m;
  step_t [MAX_STEPS-1:0]  red_steps;
  step_t                  out_n;
  logic                   busy_n;
  logic                   done_n;

  shift_count_reduce u_reduce (
    .op    (shop_t'(op)),
    .count (count),
    .m     (red_m),
    .steps (red_steps)
  );

  // Next state and next registered output values.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    out_n   = STEP_IDLE;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          busy_n = 1'b1;
          idx_n  = 2'd0;
          if (red_m == 3'd0) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = S_STEP;
            out_n   = red_steps[0];
          end
        end
      end
      S_STEP: begin
        busy_n = 1'b1;
        if ({1'b0, idx} + 3'd1 < m_q) begin
          idx_n = idx + 2'd1;
          out_n = sbuf[idx + 2'd1];
        end else begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State register and step index.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= 2'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Capture the step list when an operation is accepted.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      sbuf <= red_steps;
      m_q  <= red_m;
    end
  end

  // Registered outputs toward the AR/ARX/BR load muxes.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      sh_func <= SH_AR;
      sc      <= 6'd0;
      ar_sel  <= AR_HOLD;
      arx_sel <= ARX_HOLD;
      br_load <= 1'b0;
    end else begin
      busy    <= busy_n;
      done    <= done_n;
      sh_func <= func_of(out_n);
      sc      <= out_n.sc;
      ar_sel  <= out_n.ar_sel;
      arx_sel <= out_n.arx_sel;
      br_load <= out_n.br_load;
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq.
// Directed test-plan cases plus random ops vs. an arithmetic model.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic [8:0] count;
  logic       busy;
  logic       done;
  logic [1:0] sh_func;
  logic [5:0] sc;
  logic [2:0] ar_sel;
  logic [2:0] arx_sel;
  logic       br_load;

  int nvec = 0;
  int nerr = 0;

  localparam int H  = 0;
  localparam int SH = 1;
  localparam int XA = 2;
  localparam int BR = 3;
  localparam int Z  = 4;

  typedef struct {
    int sc;
    int ar;
    int arx;
    int br;
  } exp_t;

  exp_t eq[$];

  shift_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .sh_func (sh_func),
    .sc      (sc),
    .ar_sel  (ar_sel),
    .arx_sel (arx_sel),
    .br_load (br_load)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int a, input int x, input int b);
    exp_t e;
    e.sc = s;
    e.ar = a;
    e.arx = x;
    e.br = b;
    eq.push_back(e);
  endtask

  // Step list derived directly from the shift rules with plain arithmetic.
  task automatic build(input int o, input int v);
    int n;
    int r;
    int k;
    bit left;
    eq.delete();
    n = (v < 0) ? -v : v;
    left = (v >= 0);
    case (o)
      0: begin
        if (n >= 36) push(0, Z, H, 0);
        else if (n > 0 && left) begin
          push(0, H, Z, 0);
          push(n, SH, H, 0);
        end else if (n > 0) begin
          push(0, Z, XA, 0);
          push(36 - n, SH, H, 0);
        end
      end
      1: begin
        r = n % 36;
        if (!left) r = (36 - r) % 36;
        if (r != 0) begin
          push(0, H, XA, 0);
          push(r, SH, H, 0);
        end
      end
      3: begin
        r = n % 72;
        if (!left) r = (72 - r) % 72;
        if (r >= 36) begin
          push(0, XA, XA, 0);
          r -= 36;
        end
        if (r > 0) begin
          push(r, H, H, 1);
          push(0, XA, XA, 0);
          push(r, BR, SH, 0);
        end
      end
      default: begin
        k = n - 36;
        if (n >= 72) push(0, Z, Z, 0);
        else if (n >= 36 && left) begin
          push(0, XA, Z, 0);
          if (k > 0) push(k, SH, H, 0);
        end else if (n >= 36) begin
          push(0, Z, XA, 0);
          if (k > 0) push(36 - k, H, SH, 0);
        end else if (n > 0 && left) begin
          push(n, H, H, 1);
          push(0, XA, Z, 0);
          push(n, BR, SH, 0);
        end else if (n > 0) begin
          push(36 - n, H, H, 1);
          push(0, Z, XA, 0);
          push(36 - n, SH, BR, 0);
        end
      end
    endcase
  endtask

  task automatic check_out(input string tag, input exp_t e,
                           input int b, input int d);
    int f;
    f = (e.ar == SH || e.arx == SH || e.br != 0) ? 0 : 1;
    chk({tag, " busy"}, int'(busy), b);
    chk({tag, " done"}, int'(done), d);
    chk({tag, " sh_func"}, int'(sh_func), f);
    chk({tag, " sc"}, int'(sc), e.sc);
    chk({tag, " ar_sel"}, int'(ar_sel), e.ar);
    chk({tag, " arx_sel"}, int'(arx_sel), e.arx);
    chk({tag, " br_load"}, int'(br_load), e.br);
  endtask

  task automatic run_op(input int o, input int v,
                        input int rst_cyc, input bit repulse);
    exp_t idle;
    exp_t e;
    int m;
    string tag;
    logic [8:0] c9;
    idle = '{sc: 0, ar: H, arx: H, br: 0};
    build(o, v);
    m = eq.size();
    c9 = 9'(v);
    op = 2'(o);
    count = c9;
    start = 1'b1;
    cyc();
    start = 1'b0;
    op = 2'($urandom);
    count = 9'($urandom);
    for (int c = 1; c <= m + 2; c++) begin
      tag = $sformatf("op%0d cnt%0d c%0d", o, v, c);
      if (c <= m) begin
        e = eq[c - 1];
        check_out(tag, e, 1, 0);
      end else if (c == m + 1) begin
        check_out(tag, idle, 1, 1);
      end else begin
        check_out(tag, idle, 0, 0);
      end
      if (c == rst_cyc) begin
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_out({tag, " rst+1"}, idle, 0, 0);
        cyc();
        check_out({tag, " rst+2"}, idle, 0, 0);
        return;
      end
      if (repulse && (c == 2 || c == 4) && c <= m + 1) start = 1'b1;
      cyc();
      start = 1'b0;
    end
  endtask

  initial begin
    exp_t idle;
    int o;
    int v;
    idle = '{sc: 0, ar: H, arx: H, br: 0};
    reset = 1'b1;
    start = 1'b0;
    op = 2'd0;
    count = 9'd0;
    cyc();
    start = 1'b1;
    cyc();
    check_out("reset", idle, 0, 0);
    start = 1'b0;
    reset = 1'b0;
    cyc();
    check_out("post reset", idle, 0, 0);

    run_op(0, 3, 0, 0);
    run_op(0, -40, 0, 0);
    run_op(1, 0, 0, 0);
    run_op(1, -1, 0, 0);
    run_op(3, 40, 0, 0);
    run_op(3, 255, 0, 0);
    run_op(2, -10, 0, 0);
    run_op(2, -10, 0, 1);
    run_op(2, -10, 2, 0);
    run_op(2, 72, 0, 0);
    run_op(0, -256, 0, 0);
    run_op(1, -256, 0, 0);
    run_op(2, -256, 0, 0);
    run_op(3, -256, 0, 0);
    run_op(3, -36, 0, 0);
    run_op(2, 36, 0, 0);
    run_op(2, -36, 0, 0);
    run_op(2, 45, 0, 0);
    run_op(2, -50, 0, 0);
    run_op(0, 35, 0, 0);
    run_op(0, -35, 0, 0);

    for (int i = 0; i < 80; i++) begin
      o = int'($urandom_range(3, 0));
      v = int'($urandom_range(511, 0));
      if (v > 255) v = v - 512;
      run_op(o, v, 0, (i % 5) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
